// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Purpose:
//   UART transmitter with a small TX FIFO in front of it. Each frame's format
//   comes from tx_conf_i, captured at the moment the frame's word is popped.
//   Supported formats: 5..8 data bits sent LSB first, optional even/odd
//   parity, and 1, 1.5 or 2 stop bits. Bit timing is counted in baud_tick_i
//   pulses, OVERSAMPLE ticks per bit period.
//
// Parameters:
//   OVERSAMPLE  baud ticks per bit period (even, >= 4)
//   FIFO_DEPTH  TX FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i        single clock
//   rst_i        synchronous active-low reset
//   baud_tick_i  one-cycle enable at OVERSAMPLE x baud rate
//   tx_en_i      permits new frames to start (running frame always completes)
//   tx_conf_i    {data_size[1:0], stop_size[1:0], parity_en, parity_odd}
//   tx_valid_i   FIFO write strobe, accepted when tx_ready_o=1
//   tx_data_i    FIFO write data
//   break_i      (only with UART_TX_BREAK_EN) hold line low while idle
//   tx_ready_o   FIFO not full
//   busy_o       frame in progress or FIFO non-empty
//   tx_done_o    one-cycle pulse at end of each frame
//   uart_tx_o    serial line, idle high
//
// Optional feature macro: UART_TX_BREAK_EN (adds break_i).
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       baud_tick_i,
    input  logic       tx_en_i,
    input  logic [5:0] tx_conf_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
`ifdef UART_TX_BREAK_EN
    input  logic       break_i,
`endif
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       uart_tx_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_W = $clog2(2 * OVERSAMPLE);

    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
    localparam logic [TICK_W-1:0] BIT_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP15_LAST = TICK_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST  = TICK_W'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Break request, tied off when the feature is not built in.
    logic break_w;
`ifdef UART_TX_BREAK_EN
    assign break_w = break_i;
`else
    assign break_w = 1'b0;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             pop;

    // Frame engine
    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q;
    logic [5:0]        conf_q;

    // Registered outputs
    logic uart_tx_q, uart_tx_d;
    logic tx_done_q;
    logic busy_q;
    logic tx_ready_q;

    // Frame format decoded from the configuration captured at pop time
    logic [2:0]        bit_last;
    logic [7:0]        data_mask;
    logic              parity_bit;
    logic [TICK_W-1:0] stop_last;

    assign bit_last   = 3'd4 + {1'b0, conf_q[5:4]};
    assign data_mask  = 8'hFF >> (2'd3 - conf_q[5:4]);
    assign parity_bit = (^(data_q & data_mask)) ^ conf_q[0];

    always_comb begin
        stop_last = STOP2_LAST;
        case (conf_q[3:2])
            2'b00:   stop_last = BIT_LAST;
            2'b01:   stop_last = STOP15_LAST;
            default: stop_last = STOP2_LAST;
        endcase
    end

    // tx_ready_q always equals "FIFO not full" for the current occupancy, so
    // a write offered while full is simply not accepted.
    assign wr_en = tx_valid_i && tx_ready_q;

    // Next-state logic. Tick counter is cleared on every state entry.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only words already stored can be popped: count_q excludes
                // a write arriving on this same edge.
                if ((count_q != '0) && tx_en_i && !break_w) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_tick_i) begin
                    if (tick_q == BIT_LAST) begin
                        state_d = S_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick_i) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d = '0;
                        if (bit_q == bit_last) begin
                            state_d = conf_q[1] ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick_i) begin
                    if (tick_q == BIT_LAST) begin
                        state_d = S_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick_i) begin
                    if (tick_q == stop_last) begin
                        state_d = S_DONE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Line level for the current state; registered one cycle later.
    always_comb begin
        uart_tx_d = 1'b1;
        case (state_q)
            S_IDLE:   uart_tx_d = ~break_w;
            S_START:  uart_tx_d = 1'b0;
            S_DATA:   uart_tx_d = data_q[bit_q];
            S_PARITY: uart_tx_d = parity_bit;
            default:  uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            conf_q     <= '0;
            uart_tx_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                data_q   <= mem_q[rd_ptr_q];
                conf_q   <= tx_conf_i;
            end
            uart_tx_q  <= uart_tx_d;
            tx_done_q  <= (state_q == S_DONE);
            busy_q     <= (state_d != S_IDLE) || (count_d != '0);
            tx_ready_q <= (count_d != FULL_CNT);
        end
    end

    // FIFO array: no reset, emptiness is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    assign uart_tx_o  = uart_tx_q;
    assign tx_done_o  = tx_done_q;
    assign busy_o     = busy_q;
    assign tx_ready_o = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Bench for uart_tx_fifo (OVERSAMPLE=16, FIFO_DEPTH=4). A frame-level model
// expands each popped word into its tick-by-tick line waveform and tracks
// FIFO occupancy with a queue; every cycle the DUT outputs are compared with
// it. Directed scenarios add hand-computed literal checks on top.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_en     = 1'b0;
    logic [5:0] tx_conf   = 6'd0;
    logic       tx_valid  = 1'b0;
    logic [7:0] tx_data   = 8'd0;
    logic       brk       = 1'b0;
    logic       tx_ready, busy, tx_done, uart_tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tick_div = 1;

    always #5 clk = ~clk;

    uart_tx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .baud_tick_i (baud_tick),
        .tx_en_i     (tx_en),
        .tx_conf_i   (tx_conf),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
`ifdef UART_TX_BREAK_EN
        .break_i     (brk),
`endif
        .tx_ready_o  (tx_ready),
        .busy_o      (busy),
        .tx_done_o   (tx_done),
        .uart_tx_o   (uart_tx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         lv[$];
    int         phase = 0;   // 0 idle, 1 frame on the wire, 2 done cycle
    int         pos = 0;
    int         pop_cnt = 0;
    int         pop_cyc = 0;
    logic       exp_line = 1'b1, exp_done = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;

    function automatic void build(input logic [7:0] d, input logic [5:0] c);
        int nb;
        int st;
        bit p;
        lv.delete();
        nb = 5 + int'(c[5:4]);
        repeat (OS) lv.push_back(1'b0);
        p = c[0];
        for (int i = 0; i < nb; i++) begin
            p = p ^ d[i];
            repeat (OS) lv.push_back(d[i]);
        end
        if (c[1]) repeat (OS) lv.push_back(p);
        st = (c[3:2] == 2'b00) ? OS : (c[3:2] == 2'b01) ? (3 * OS) / 2 : 2 * OS;
        repeat (st) lv.push_back(1'b1);
    endfunction

    task automatic model_step();
        bit wr;
        bit pp;
        logic [7:0] w;
        if (!rst_n) begin
            mq.delete();
            lv.delete();
            phase = 0;
            pos = 0;
            exp_line = 1'b1;
            exp_done = 1'b0;
            exp_busy = 1'b0;
            exp_ready = 1'b1;
        end else begin
            exp_line = (phase == 1) ? lv[pos] : ((phase == 0 && brk) ? 1'b0 : 1'b1);
            exp_done = (phase == 2);
            wr = tx_valid && (mq.size() < DEPTH);
            pp = (phase == 0) && (mq.size() > 0) && tx_en && !brk;
            if (phase == 2) phase = 0;
            else if (phase == 1 && baud_tick) begin
                pos++;
                if (pos == lv.size()) phase = 2;
            end
            if (pp) begin
                w = mq.pop_front();
                build(w, tx_conf);
                phase = 1;
                pos = 0;
                pop_cnt++;
                pop_cyc = cyc;
            end
            if (wr) mq.push_back(tx_data);
            exp_ready = (mq.size() < DEPTH);
            exp_busy = (phase != 0) || (mq.size() > 0);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        chk("line", uart_tx, exp_line);
        chk("done", tx_done, exp_done);
        chk("busy", busy, exp_busy);
        chk("ready", tx_ready, exp_ready);
        if (tx_done) $display("frame done at cycle %0d", cyc);
    end

    // Baud tick source: every tick_div-th cycle.
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tc++;
            baud_tick = (tick_div <= 1) ? 1'b1 : ((tc % tick_div) == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_pop(input int prev);
        int n;
        n = 0;
        while (pop_cnt == prev && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("pop_seen", (pop_cnt != prev), 1);
    endtask

    task automatic wait_done(input int max, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", tx_done, 1);
        t = cyc;
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx_done) c++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int p, pc, t, c;
        int td[4];
        logic [9:0] a5_frame;
        int off2[9];
        logic [8:0] val2;
        int off4[4];
        logic [3:0] val4;

        // Reset
        rst_n = 1'b0;
        step(3);
        chk("rst_line", uart_tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        rst_n = 1'b1;
        step(2);

        // 8N1, word A5, tick every cycle
        tx_conf = 6'b11_00_00;
        tx_en   = 1'b1;
        p = pop_cnt;
        write_word(8'hA5);
        chk("busy_after_write", busy, 1);
        wait_pop(p);
        pc = pop_cyc;
        a5_frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_cyc(pc + 16 * k + 8);
            chk("a5_bit", uart_tx, a5_frame[k]);
        end
        wait_done(400, t);
        chk("a5_done_latency", t - pc, 161);

        // 5 data bits, 1.5 stop, odd parity, word FF
        tx_conf = 6'b00_01_11;
        p = pop_cnt;
        write_word(8'hFF);
        wait_pop(p);
        pc = pop_cyc;
        off2 = '{8, 24, 40, 56, 72, 88, 104, 120, 136};
        val2 = 9'b1_1_0_11111_0;   // index 0 = start ... index 8 = end of stop
        for (int k = 0; k < 9; k++) begin
            wait_cyc(pc + off2[k]);
            chk("ff_bit", uart_tx, val2[k]);
        end
        wait_done(400, t);
        chk("ff_done_latency", t - pc, 137);

        // Fill FIFO while disabled, overflow, then drain back-to-back
        tx_en   = 1'b0;
        tx_conf = 6'b11_00_00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 3) chk("ready_at_3", tx_ready, 1);
            if (i == 4) chk("ready_full", tx_ready, 0);
            tx_valid = 1'b1;
            tx_data  = 8'h30 + 8'(i);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_after_drop", tx_ready, 0);
        step(20);
        chk("hold_busy", busy, 1);
        chk("hold_line", uart_tx, 1);
        tx_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_done(500, td[f]);
        end
        for (int f = 1; f < 4; f++) begin
            chk("b2b_spacing", td[f] - td[f-1], 162);
        end
        count_done(250, c);
        chk("no_fifth_frame", c, 0);
        chk("drained_busy", busy, 0);

        // Mid-frame conf change and disable
        tx_conf = 6'b11_00_10;
        tx_en   = 1'b1;
        p = pop_cnt;
        write_word(8'h3C);
        write_word(8'h81);
        wait_pop(p);
        pc = pop_cyc;
        wait_cyc(pc + 40);
        tx_conf = 6'b00_10_01;
        tx_en   = 1'b0;
        off4 = '{104, 120, 152, 168};
        val4 = 4'b1_0_0_1;         // bit5, bit6, parity, stop (index 0 first)
        for (int k = 0; k < 4; k++) begin
            wait_cyc(pc + off4[k]);
            chk("conf_hold_bit", uart_tx, val4[k]);
        end
        wait_done(400, t);
        chk("conf_hold_latency", t - pc, 177);
        count_done(150, c);
        chk("disabled_no_frame", c, 0);
        chk("disabled_busy", busy, 1);

        // Reset during DATA with words queued
        tx_conf = 6'b11_00_00;
        p = pop_cnt;
        tx_en = 1'b1;
        wait_pop(p);
        pc = pop_cyc;
        write_word(8'h55);
        write_word(8'h66);
        wait_cyc(pc + 40);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_line", uart_tx, 1);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", tx_done, 0);
        rst_n = 1'b1;
        count_done(250, c);
        chk("midrst_no_done", c, 0);
        chk("midrst_idle", busy, 0);

        // Slow ticks, simultaneous write and pop
        tick_div = 3;
        tx_en    = 1'b0;
        tx_conf  = 6'b01_11_10;
        write_word(8'h2A);
        @(negedge clk);
        tx_en    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h15;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("rw_ready", tx_ready, 1);
        chk("rw_busy", busy, 1);
        wait_done(1200, t);
        wait_done(1200, t);
        count_done(600, c);
        chk("rw_two_frames", c, 0);
        tick_div = 1;
        step(5);

`ifdef UART_TX_BREAK_EN
        brk = 1'b1;
        write_word(8'h5A);
        for (int k = 0; k < 5; k++) begin
            step(10);
            chk("break_low", uart_tx, 0);
        end
        chk("break_busy", busy, 1);
        p = pop_cnt;
        brk = 1'b0;
        wait_pop(p);
        pc = pop_cyc;
        wait_cyc(pc + 30);
        brk = 1'b1;
        wait_done(400, t);
        chk("break_done_latency", t - pc, 161);
        step(3);
        chk("break_after_frame", uart_tx, 0);
        brk = 1'b0;
        step(3);
        chk("break_release_line", uart_tx, 1);
`endif

        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
